ahb_job_queue: RTL and testbench

Command queue and sequencer directly upstream of `data_worker`, the AHB manager. It buffers up to `pQUEUE_DEPTH` read/write jobs from a system-side producer and issues them one at a time on the worker's `go`/`done` job interface. It captures read data, guards each job with a timeout, and returns one response per job through a valid/ready port.

---
 rtl/ahb_job_queue_if.sv | 55 +++++
 rtl/ahb_job_queue.sv | 172 +++++++++++++++++
 tb/tb_ahb_job_queue.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_job_queue_if.sv
// ahb_job_queue_if: bundles every non-clock signal of ahb_job_queue.
//   slave  modport: the queue itself (takes I_* inputs, drives O_* outputs).
//   master modport: the surrounding system (producer, worker, consumer).
// Signal groups:
//   cmd  : I_cmd_valid/O_cmd_ready handshake plus I_cmd_write/addr/wdata.
//   job  : O_go/I_done with O_int_addr/wdata/write and I_int_rdata(_valid).
//   rsp  : O_rsp_valid/I_rsp_ready handshake plus O_rsp_write/rdata/err.
//   misc : O_count (FIFO occupancy), O_busy, dbg_state (FSM state).
interface ahb_job_queue_if #(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128,
  parameter int pQUEUE_DEPTH       = 4
);
  localparam int CW = $clog2(pQUEUE_DEPTH) + 1;

  logic                          I_cmd_valid;
  logic                          O_cmd_ready;
  logic                          I_cmd_write;
  logic [pAHB_ADDR_WIDTH-1:0]    I_cmd_addr;
  logic [pPAYLOAD_SIZE_BITS-1:0] I_cmd_wdata;

  logic [pAHB_ADDR_WIDTH-1:0]    O_int_addr;
  logic [pPAYLOAD_SIZE_BITS-1:0] O_int_wdata;
  logic                          O_int_write;
  logic                          O_go;
  logic                          I_done;
  logic [pPAYLOAD_SIZE_BITS-1:0] I_int_rdata;
  logic                          I_int_rdata_valid;

  logic                          O_rsp_valid;
  logic                          I_rsp_ready;
  logic                          O_rsp_write;
  logic [pPAYLOAD_SIZE_BITS-1:0] O_rsp_rdata;
  logic                          O_rsp_err;

  logic [CW-1:0]                 O_count;
  logic                          O_busy;
  logic [1:0]                    dbg_state;

  modport slave (
    input  I_cmd_valid, I_cmd_write, I_cmd_addr, I_cmd_wdata,
    input  I_done, I_int_rdata, I_int_rdata_valid, I_rsp_ready,
    output O_cmd_ready, O_int_addr, O_int_wdata, O_int_write, O_go,
    output O_rsp_valid, O_rsp_write, O_rsp_rdata, O_rsp_err,
    output O_count, O_busy, dbg_state
  );

  modport master (
    output I_cmd_valid, I_cmd_write, I_cmd_addr, I_cmd_wdata,
    output I_done, I_int_rdata, I_int_rdata_valid, I_rsp_ready,
    input  O_cmd_ready, O_int_addr, O_int_wdata, O_int_write, O_go,
    input  O_rsp_valid, O_rsp_write, O_rsp_rdata, O_rsp_err,
    input  O_count, O_busy, dbg_state
  );
endinterface

// File: rtl/ahb_job_queue.sv
// ahb_job_queue: command FIFO and job sequencer in front of the AHB worker.
// Buffers read/write jobs, issues them one at a time on O_go/I_done,
// captures read data, times out stuck jobs, and returns one response per job.
// Ports:
//   clk  : clock, rising edge.
//   rst  : asynchronous active-high reset.
//   bus  : ahb_job_queue_if.slave (command, worker job, response, status).
// Handshakes: a transfer on cmd or rsp happens on a rising edge where valid
// and ready are both high; valid never depends on ready, and a source keeps
// its payload stable while valid is high and ready is low.
module ahb_job_queue #(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128,
  parameter int pQUEUE_DEPTH       = 4,
  parameter int pJOB_TIMEOUT       = 64
) (
  input  logic            clk,
  input  logic            rst,
  ahb_job_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(pQUEUE_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam int TMO_W = $clog2(pJOB_TIMEOUT + 1);
  localparam int ENT_W = 1 + pAHB_ADDR_WIDTH + pPAYLOAD_SIZE_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nxt;

  // FIFO: entries are {write, addr, wdata}
  logic [ENT_W-1:0] mem [pQUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;

  logic done_evt, tmo_evt;

  // Job register and per-job tracking
  logic                          job_write;
  logic [pAHB_ADDR_WIDTH-1:0]    job_addr;
  logic [pPAYLOAD_SIZE_BITS-1:0] job_wdata;
  logic                          go;
  logic [TMO_W-1:0]              age;
  logic                          cap;
  logic [pPAYLOAD_SIZE_BITS-1:0] cap_data;

  // Response register
  logic                          rsp_valid, rsp_write, rsp_err;
  logic [pPAYLOAD_SIZE_BITS-1:0] rsp_rdata;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign push  = bus.I_cmd_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= {bus.I_cmd_write, bus.I_cmd_addr, bus.I_cmd_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_evt  = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Done wins over a timeout landing on the same edge.
        if (bus.I_done) begin
          done_evt  = 1'b1;
          state_nxt = RESP;
        end else if (age == TMO_W'(pJOB_TIMEOUT)) begin
          tmo_evt   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // rsp_valid is always high here, so ready alone completes the handshake.
        if (bus.I_rsp_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_write <= 1'b0;
      job_addr  <= '0;
      job_wdata <= '0;
      go        <= 1'b0;
      age       <= '0;
      cap       <= 1'b0;
      cap_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (state == RESP && bus.I_rsp_ready) rsp_valid <= 1'b0;
      if (pop) begin
        {job_write, job_addr, job_wdata} <= mem[rd_ptr[IDX_W-1:0]];
        go       <= 1'b1;
        age      <= '0;
        cap      <= 1'b0;
        cap_data <= '0;
      end
      if (state == ISSUE) begin
        if (bus.I_int_rdata_valid) begin
          cap      <= 1'b1;
          cap_data <= bus.I_int_rdata;
        end
        if (done_evt) begin
          go        <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_write <= job_write;
          // Data arriving together with done counts as captured.
          if (job_write) rsp_rdata <= '0;
          else if (bus.I_int_rdata_valid) rsp_rdata <= bus.I_int_rdata;
          else rsp_rdata <= cap_data;
          rsp_err <= !job_write && !bus.I_int_rdata_valid && !cap;
        end else if (tmo_evt) begin
          go        <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_write <= job_write;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else begin
          age <= age + 1'b1;
        end
      end
    end
  end

  assign bus.O_cmd_ready = !full;
  assign bus.O_int_addr  = job_addr;
  assign bus.O_int_wdata = job_wdata;
  assign bus.O_int_write = job_write;
  assign bus.O_go        = go;
  assign bus.O_rsp_valid = rsp_valid;
  assign bus.O_rsp_write = rsp_write;
  assign bus.O_rsp_rdata = rsp_rdata;
  assign bus.O_rsp_err   = rsp_err;
  assign bus.O_count     = wr_ptr - rd_ptr;
  assign bus.O_busy      = (state != IDLE) || !empty;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_ahb_job_queue.sv
// tb_ahb_job_queue: directed bench for ahb_job_queue with a job-level
// reference model (command queue + current job + pending response) checked
// against the DUT on every falling edge, plus hand-computed expectations.
module tb_ahb_job_queue;
  localparam int AW    = 32;
  localparam int PW    = 128;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int RW    = PW + 2;

  localparam logic [PW-1:0] D1 = 128'h31c3001967d4acf1bcb25768708627ae;
  localparam logic [PW-1:0] D2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_job_queue_if #(.pAHB_ADDR_WIDTH(AW), .pPAYLOAD_SIZE_BITS(PW), .pQUEUE_DEPTH(DEPTH)) bus ();

  ahb_job_queue #(
    .pAHB_ADDR_WIDTH(AW), .pPAYLOAD_SIZE_BITS(PW),
    .pQUEUE_DEPTH(DEPTH), .pJOB_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- scoreboard + reference model ----------------
  // exp_q holds {err, write, rdata} per job in push order.
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [PW-1:0] d;
  } job_t;

  job_t          mq[$];
  job_t          m_job;
  int            m_phase;   // 0 no job, 1 job outstanding, 2 response pending
  int            m_cyc;
  int            m_start;
  bit            m_cap;
  logic [PW-1:0] m_capd;
  logic [RW-1:0] m_rsp;

  function automatic void m_respond(input logic err, input logic [PW-1:0] rd);
    m_rsp   = {err, m_job.w, rd};
    m_phase = 2;
    check("sb_pending", RW'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) check("sb_rsp_order", m_rsp, exp_q.pop_front());
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_phase = 0;
      m_cap   = 1'b0;
      m_capd  = '0;
      m_rsp   = '0;
      m_cyc   = 0;
      m_start = 0;
    end else begin
      int sz0;
      bit start;
      m_cyc++;
      sz0   = mq.size();
      start = 1'b0;
      if (m_phase == 1) begin
        if (bus.I_int_rdata_valid) begin
          m_cap  = 1'b1;
          m_capd = bus.I_int_rdata;
        end
        if (bus.I_done) m_respond(!m_job.w && !m_cap, m_job.w ? {PW{1'b0}} : m_capd);
        else if (m_cyc - m_start == TMO + 1) m_respond(1'b1, {PW{1'b0}});
      end else if (m_phase == 0) begin
        start = (sz0 > 0);
      end else if (bus.I_rsp_ready) begin
        if (sz0 > 0) start = 1'b1;
        else m_phase = 0;
      end
      if (start) begin
        m_job   = mq.pop_front();
        m_phase = 1;
        m_start = m_cyc;
        m_cap   = 1'b0;
        m_capd  = '0;
      end
      if (bus.I_cmd_valid && sz0 < DEPTH)
        mq.push_back('{bus.I_cmd_write, bus.I_cmd_addr, bus.I_cmd_wdata});
    end
  end

  // Compare process: DUT outputs vs model, once per cycle away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("go", bus.O_go, m_phase == 1);
      if (m_phase == 1) begin
        check("int_addr", bus.O_int_addr, m_job.a);
        check("int_wdata", bus.O_int_wdata, m_job.d);
        check("int_write", bus.O_int_write, m_job.w);
      end
      check("rsp_valid", bus.O_rsp_valid, m_phase == 2);
      if (m_phase == 2) check("rsp_fields", {bus.O_rsp_err, bus.O_rsp_write, bus.O_rsp_rdata}, m_rsp);
      check("count", bus.O_count, mq.size());
      check("cmd_ready", bus.O_cmd_ready, mq.size() < DEPTH);
      check("busy", bus.O_busy, (m_phase != 0) || (mq.size() > 0));
    end
  end

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic push_cmd(input bit w, input logic [AW-1:0] a, input logic [PW-1:0] d);
    int n;
    n = 0;
    bus.I_cmd_valid = 1'b1;
    bus.I_cmd_write = w;
    bus.I_cmd_addr  = a;
    bus.I_cmd_wdata = d;
    while (!bus.O_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", RW'(n < 100), 1);
    @(negedge clk);
    bus.I_cmd_valid = 1'b0;
  endtask

  task automatic wait_go();
    int n;
    n = 0;
    while (!bus.O_go && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("go_wait", RW'(n < 100), 1);
  endtask

  task automatic done_pulse(input bit v, input logic [PW-1:0] d);
    bus.I_done            = 1'b1;
    bus.I_int_rdata_valid = v;
    bus.I_int_rdata       = d;
    @(negedge clk);
    bus.I_done            = 1'b0;
    bus.I_int_rdata_valid = 1'b0;
    bus.I_int_rdata       = '0;
  endtask

  function automatic logic [PW-1:0] wd(input int k);
    return {4{32'h5000_0000 + 32'(k)}};
  endfunction

  function automatic logic [PW-1:0] rd(input int k);
    return {4{32'ha5a5_0000 + 32'(k)}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.I_cmd_valid       = 1'b0;
    bus.I_cmd_write       = 1'b0;
    bus.I_cmd_addr        = '0;
    bus.I_cmd_wdata       = '0;
    bus.I_done            = 1'b0;
    bus.I_int_rdata       = '0;
    bus.I_int_rdata_valid = 1'b0;
    bus.I_rsp_ready       = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_go", bus.O_go, 0);
    check("rst_rsp_valid", bus.O_rsp_valid, 0);
    check("rst_count", bus.O_count, 0);
    check("rst_cmd_ready", bus.O_cmd_ready, 1);
    check("rst_busy", bus.O_busy, 0);
    check("rst_rsp_rdata", bus.O_rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write: go two cycles after the command is offered.
    exp_q.push_back({1'b0, 1'b1, {PW{1'b0}}});
    push_cmd(1'b1, 32'h10, D1);
    check("w_go_not_yet", bus.O_go, 0);
    check("w_count_1", bus.O_count, 1);
    @(negedge clk);
    check("w_go", bus.O_go, 1);
    check("w_addr", bus.O_int_addr, 32'h10);
    check("w_wdata", bus.O_int_wdata, D1);
    repeat (5) @(negedge clk);
    done_pulse(1'b0, '0);
    check("w_rsp_valid", bus.O_rsp_valid, 1);
    check("w_rsp_write", bus.O_rsp_write, 1);
    check("w_rsp_err", bus.O_rsp_err, 0);
    check("w_rsp_rdata", bus.O_rsp_rdata, 0);
    check("w_go_low", bus.O_go, 0);
    @(negedge clk);
    check("w_rsp_taken", bus.O_rsp_valid, 0);
    check("w_idle", bus.O_busy, 0);

    // Read with data on the done cycle.
    exp_q.push_back({1'b0, 1'b0, D2});
    push_cmd(1'b0, 32'h20, '0);
    wait_go();
    repeat (2) @(negedge clk);
    done_pulse(1'b1, D2);
    check("r_rdata", bus.O_rsp_rdata, D2);
    check("r_err", bus.O_rsp_err, 0);
    check("r_write", bus.O_rsp_write, 0);
    @(negedge clk);

    // Read completed without data.
    exp_q.push_back({1'b1, 1'b0, {PW{1'b0}}});
    push_cmd(1'b0, 32'h30, '0);
    wait_go();
    repeat (3) @(negedge clk);
    done_pulse(1'b0, '0);
    check("nd_err", bus.O_rsp_err, 1);
    check("nd_rdata", bus.O_rsp_rdata, 0);
    @(negedge clk);

    // Full FIFO and response back-pressure.
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) exp_q.push_back({1'b0, 1'b1, {PW{1'b0}}});
      else            exp_q.push_back({1'b0, 1'b0, rd(k)});
      push_cmd(k % 2 == 0, 32'h100 + 32'(16 * k), wd(k));
    end
    check("full_count", bus.O_count, 4);
    check("full_ready", bus.O_cmd_ready, 0);
    check("full_go", bus.O_go, 1);
    check("full_addr0", bus.O_int_addr, 32'h100);
    bus.I_rsp_ready = 1'b0;
    done_pulse(1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", bus.O_rsp_valid, 1);
      check("bp_write", bus.O_rsp_write, 1);
      check("bp_err", bus.O_rsp_err, 0);
      check("bp_no_go", bus.O_go, 0);
      check("bp_count", bus.O_count, 4);
      @(negedge clk);
    end
    bus.I_rsp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      wait_go();
      check("order_addr", bus.O_int_addr, 32'h100 + 32'(16 * k));
      if (k == 3) begin
        // Data arrives a cycle ahead of done and must be remembered.
        bus.I_int_rdata_valid = 1'b1;
        bus.I_int_rdata       = rd(k);
        @(negedge clk);
        bus.I_int_rdata_valid = 1'b0;
        bus.I_int_rdata       = '0;
        done_pulse(1'b0, '0);
      end else begin
        done_pulse(k % 2 == 1, rd(k));
      end
    end
    @(negedge clk);

    // Timeout: go held for exactly TMO+1 edges.
    exp_q.push_back({1'b1, 1'b0, {PW{1'b0}}});
    push_cmd(1'b0, 32'h40, '0);
    wait_go();
    n = 0;
    while (bus.O_go && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("tmo_go_cycles", RW'(n), 65);
    check("tmo_err", bus.O_rsp_err, 1);
    check("tmo_rdata", bus.O_rsp_rdata, 0);
    check("tmo_valid", bus.O_rsp_valid, 1);
    @(negedge clk);

    // Done on exactly the timeout edge completes normally.
    exp_q.push_back({1'b0, 1'b1, {PW{1'b0}}});
    push_cmd(1'b1, 32'h50, wd(9));
    wait_go();
    repeat (64) @(negedge clk);
    check("tmo_edge_go", bus.O_go, 1);
    done_pulse(1'b0, '0);
    check("tmo_edge_err", bus.O_rsp_err, 0);
    check("tmo_edge_write", bus.O_rsp_write, 1);
    @(negedge clk);

    // Reset mid-job with two commands queued.
    for (int k = 0; k < 3; k++) push_cmd(1'b0, 32'h60 + 32'(k), '0);
    check("mid_go", bus.O_go, 1);
    check("mid_count", bus.O_count, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_go", bus.O_go, 0);
    check("mid_rst_count", bus.O_count, 0);
    check("mid_rst_rsp", bus.O_rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_rsp", bus.O_rsp_valid, 0);
    check("post_rst_go", bus.O_go, 0);
    check("post_rst_busy", bus.O_busy, 0);

    check("exp_q_drained", RW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
